// File: rtl/regfile_pkg.sv
// Shared types and helpers for the lane-writable register bank.
// Optional same-cycle write bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  // Scrub sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCRUB = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Lane width in bits for an entry of `width` bits split into `lanes` lanes
  function automatic int lw(input int width, input int lanes);
    return width / lanes;
  endfunction

endpackage

// File: rtl/regfile_lanes_if.sv
// Bus bundle for regfile_lanes: write port, two read ports, scrub handshake
// and a debug view of the scrub sequencer state.
//
// Handshake: scrub_req is a level sampled only while the sequencer is IDLE;
// once taken, busy stays high for exactly DEPTH cycles, then done pulses for
// one cycle. Requests seen while busy or done are dropped, not queued.
// Writes need no handshake: any cycle with we=1 outside SCRUB is accepted.
interface regfile_lanes_if #(
  parameter int WIDTH = 16,
  parameter int LANES = 2,
  parameter int DEPTH = 8
);
  import regfile_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic             we;
  logic [AW-1:0]    waddr;
  logic [LANES-1:0] wlane;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_a;
  logic [WIDTH-1:0] rdata_b;
  logic             scrub_req;
  logic             busy;
  logic             done;
  logic             wr_err;
  state_e           dbg_state;

  modport master (
    output we, waddr, wlane, wdata, raddr_a, raddr_b, scrub_req,
    input  rdata_a, rdata_b, busy, done, wr_err, dbg_state
  );

  modport slave (
    input  we, waddr, wlane, wdata, raddr_a, raddr_b, scrub_req,
    output rdata_a, rdata_b, busy, done, wr_err, dbg_state
  );

endinterface

// File: rtl/lane_reg.sv
// One register-bank entry: per-lane load mask, synchronous zero (used by
// the scrub sequencer, wins over load) and asynchronous clear.
module lane_reg #(
  parameter int WIDTH = 16,
  parameter int LANES = 2
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             zero_i,
  input  logic [LANES-1:0] load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  import regfile_pkg::*;

  localparam int LW = lw(WIDTH, LANES);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next value: zero the whole entry, or merge the selected lanes
  always_comb begin
    q_d = q_q;
    if (zero_i) begin
      q_d = '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (load_i[l]) q_d[l*LW +: LW] = d_i[l*LW +: LW];
      end
    end
  end

  // Entry storage with asynchronous clear
  always_ff @(posedge clk or posedge clear) begin
    if (clear) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/regfile_lanes.sv
// Lane-writable register bank with two combinational read ports and a
// hardware scrub sequencer that zeroes one entry per cycle.
// Define REGFILE_BYPASS_EN to forward accepted write data to a read port
// addressing the entry being written in the same cycle.
module regfile_lanes #(
  parameter int WIDTH = 16,
  parameter int LANES = 2,
  parameter int DEPTH = 8
) (
  input logic           clk,
  input logic           clear,
  regfile_lanes_if.slave bus
);
  import regfile_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lw(WIDTH, LANES);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e        state_q;
  logic [AW-1:0] ptr_q;
  logic          wr_err_q;
  logic          wr_accept;
  logic [WIDTH-1:0] ent [DEPTH];

  // Writes are only honoured outside the scrub window
  assign wr_accept = bus.we && (state_q == IDLE || state_q == DONE);

  // Scrub sequencer, scrub pointer and dropped-write flag
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= bus.we && (state_q == SCRUB);
      case (state_q)
        IDLE: begin
          if (bus.scrub_req) begin
            state_q <= SCRUB;
            ptr_q   <= '0;
          end
        end
        SCRUB: begin
          ptr_q <= ptr_q + AW'(1);
          if (ptr_q == LAST) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Entry array with write/scrub decode
  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    logic [LANES-1:0] load;
    logic             zero;

    assign load = (wr_accept && bus.waddr == AW'(e)) ? bus.wlane : '0;
    assign zero = (state_q == SCRUB) && (ptr_q == AW'(e));

    lane_reg #(
      .WIDTH (WIDTH),
      .LANES (LANES)
    ) u_reg (
      .clk    (clk),
      .clear  (clear),
      .zero_i (zero),
      .load_i (load),
      .d_i    (bus.wdata),
      .q_o    (ent[e])
    );
  end

  // Combinational read ports, optionally forwarding the accepted write
  always_comb begin
    bus.rdata_a = ent[bus.raddr_a];
    bus.rdata_b = ent[bus.raddr_b];
`ifdef REGFILE_BYPASS_EN
    for (int l = 0; l < LANES; l++) begin
      if (wr_accept && bus.wlane[l] && bus.raddr_a == bus.waddr)
        bus.rdata_a[l*LW +: LW] = bus.wdata[l*LW +: LW];
      if (wr_accept && bus.wlane[l] && bus.raddr_b == bus.waddr)
        bus.rdata_b[l*LW +: LW] = bus.wdata[l*LW +: LW];
    end
`endif
  end

  assign bus.busy      = (state_q == SCRUB);
  assign bus.done      = (state_q == DONE);
  assign bus.wr_err    = wr_err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_regfile_lanes.sv
// Directed bench for regfile_lanes (WIDTH=16, LANES=2, DEPTH=8).
module tb_regfile_lanes;
  import regfile_pkg::*;

  localparam int WIDTH = 16;
  localparam int LANES = 2;
  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic clear = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [WIDTH-1:0] model [DEPTH];
  logic [WIDTH-1:0] exp_q [$];

  regfile_lanes_if #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) bus ();

  regfile_lanes #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.we        = 1'b0;
    bus.waddr     = '0;
    bus.wlane     = '0;
    bus.wdata     = '0;
    bus.raddr_a   = '0;
    bus.raddr_b   = '0;
    bus.scrub_req = 1'b0;
  endtask

  task automatic write(input int addr, input logic [1:0] lane, input logic [15:0] data);
    bus.we    = 1'b1;
    bus.waddr = addr[2:0];
    bus.wlane = lane;
    bus.wdata = data;
    tick();
    bus.we = 1'b0;
    if (lane[0]) model[addr][7:0]  = data[7:0];
    if (lane[1]) model[addr][15:8] = data[15:8];
  endtask

  task automatic read_chk(input string tag, input int addr, input logic [15:0] exp);
    bus.raddr_a = addr[2:0];
    bus.raddr_b = addr[2:0];
    #1;
    check($sformatf("%s_a[%0d]", tag, addr), 32'(bus.rdata_a), 32'(exp));
    check($sformatf("%s_b[%0d]", tag, addr), 32'(bus.rdata_b), 32'(exp));
  endtask

  task automatic read_all(input string tag);
    logic [WIDTH-1:0] e;
    for (int a = 0; a < DEPTH; a++) exp_q.push_back(model[a]);
    for (int a = 0; a < DEPTH; a++) begin
      e = exp_q.pop_front();
      read_chk(tag, a, e);
    end
  endtask

  task automatic zero_model();
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
  endtask

  initial begin
    int cnt;
    idle_inputs();
    zero_model();

    // reset
    #2 clear = 1'b1;
    #1;
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_done",   32'(bus.done),   32'd0);
    check("rst_wr_err", 32'(bus.wr_err), 32'd0);
    check("rst_state",  32'(bus.dbg_state), 32'(IDLE));
    check("rst_rdata",  32'(bus.rdata_a), 32'd0);
    tick();
    tick();
    clear = 1'b0;
    read_all("rst_read");

    // lane writes
    write(3, 2'b11, 16'hABCD);
    read_chk("lane_full", 3, 16'hABCD);
    write(3, 2'b01, 16'h0012);
    read_chk("lane_lo", 3, 16'hAB12);
    write(3, 2'b10, 16'h5600);
    read_chk("lane_hi", 3, 16'h5612);
    write(3, 2'b00, 16'hFFFF);
    read_chk("lane_none", 3, 16'h5612);
    check("lane_none_err", 32'(bus.wr_err), 32'd0);

    // same-cycle bypass
    write(2, 2'b11, 16'h1111);
    bus.we = 1'b1; bus.waddr = 3'd2; bus.wlane = 2'b10; bus.wdata = 16'hBEEF;
    bus.raddr_a = 3'd2; bus.raddr_b = 3'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_a", 32'(bus.rdata_a), 32'h0000BE11);
`else
    check("bypass_a", 32'(bus.rdata_a), 32'h00001111);
`endif
    check("bypass_b", 32'(bus.rdata_b), 32'h00005612);
    tick();
    bus.we = 1'b0;
    model[2] = 16'hBE11;
    read_chk("bypass_after", 2, 16'hBE11);

    // full scrub
    for (int a = 0; a < DEPTH; a++) write(a, 2'b11, 16'hFFFF);
    bus.scrub_req = 1'b1;
    tick();
    bus.scrub_req = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("scrub_busy%0d", k), 32'(bus.busy), 32'd1);
      bus.raddr_a = k[2:0];
      #1;
      check($sformatf("scrub_pre%0d", k), 32'(bus.rdata_a), 32'h0000FFFF);
      tick();
      bus.raddr_a = k[2:0];
      bus.raddr_b = 3'(k + 1);
      #1;
      check($sformatf("scrub_zero%0d", k), 32'(bus.rdata_a), 32'd0);
      if (k < DEPTH - 1)
        check($sformatf("scrub_hold%0d", k + 1), 32'(bus.rdata_b), 32'h0000FFFF);
    end
    check("scrub_busy_end", 32'(bus.busy), 32'd0);
    check("scrub_done", 32'(bus.done), 32'd1);
    tick();
    check("scrub_done_end", 32'(bus.done), 32'd0);
    check("scrub_idle", 32'(bus.dbg_state), 32'(IDLE));
    zero_model();
    read_all("scrub_read");

    // write during scrub, write in DONE
    bus.scrub_req = 1'b1;
    tick();
    bus.scrub_req = 1'b0;
    tick();
    bus.we = 1'b1; bus.waddr = 3'd7; bus.wlane = 2'b11; bus.wdata = 16'h1234;
    bus.raddr_a = 3'd7;
    #1;
    check("drop_no_bypass", 32'(bus.rdata_a), 32'd0);
    tick();
    bus.we = 1'b0;
    check("drop_err", 32'(bus.wr_err), 32'd1);
    tick();
    check("drop_err_end", 32'(bus.wr_err), 32'd0);
    cnt = 0;
    while (!bus.done && cnt < 20) begin
      cnt++;
      tick();
    end
    check("drop_done_seen", 32'(bus.done), 32'd1);
    read_chk("drop_addr7", 7, 16'h0000);
    write(5, 2'b11, 16'h5A5A);
    check("done_wr_done", 32'(bus.done), 32'd0);
    read_chk("done_wr", 5, 16'h5A5A);
    read_chk("drop_addr7_late", 7, 16'h0000);

    // clear mid-scrub, then restart
    write(1, 2'b11, 16'h7777);
    write(6, 2'b11, 16'h6666);
    bus.scrub_req = 1'b1;
    tick();
    bus.scrub_req = 1'b0;
    tick();
    tick();
    tick();
    check("mid_busy", 32'(bus.busy), 32'd1);
    read_chk("mid_scrubbed1", 1, 16'h0000);
    read_chk("mid_pending6", 6, 16'h6666);
    clear = 1'b1;
    #1;
    check("mid_clr_busy", 32'(bus.busy), 32'd0);
    check("mid_clr_state", 32'(bus.dbg_state), 32'(IDLE));
    read_chk("mid_clr6", 6, 16'h0000);
    read_chk("mid_clr5", 5, 16'h0000);
    tick();
    clear = 1'b0;
    zero_model();
    write(0, 2'b11, 16'hAAAA);
    write(4, 2'b11, 16'h4444);
    bus.scrub_req = 1'b1;
    tick();
    bus.scrub_req = 1'b0;
    cnt = 0;
    while (bus.busy && cnt < 20) begin
      if (cnt == 0) read_chk("restart_e0_pre", 0, 16'hAAAA);
      if (cnt == 1) begin
        read_chk("restart_e0", 0, 16'h0000);
        read_chk("restart_e4", 4, 16'h4444);
      end
      cnt++;
      tick();
    end
    check("restart_busy_len", 32'(cnt), 32'd8);
    check("restart_done", 32'(bus.done), 32'd1);
    tick();
    zero_model();
    read_all("restart_read");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
